// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator with registered syncs, data enable, coordinates and strobes.
// Optional VGA_TIMING_FETCH_EN adds fetch_en/fetch_x, which run FETCH_LEAD clocks ahead of data_en.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 1,
   parameter int VS_POL   = 1
) (
   input  logic        clk,
   input  logic        reset,
   output logic        hsync,
   output logic        vsync,
   output logic        data_en,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame
`ifdef VGA_TIMING_FETCH_EN
   ,
   output logic        fetch_en,
   output logic [11:0] fetch_x
`endif
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic HS_ON = (HS_POL != 0);
   localparam logic VS_ON = (VS_POL != 0);
   typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYN, H_BACK} h_state_t;
   typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYN, V_BACK} v_state_t;
   logic [11:0] r_hcnt, r_vcnt;
   h_state_t    r_hst, w_hst_nxt;
   v_state_t    r_vst, w_vst_nxt;
   logic        w_hwrap, w_vwrap, w_vis;
   assign w_hwrap = (r_hcnt == 12'(H_TOTAL - 1));
   assign w_vwrap = (r_vcnt == 12'(V_TOTAL - 1));
   assign w_vis   = (r_hst == H_ACT) && (r_vst == V_ACT);
`ifndef SYNTHESIS
   initial begin
      if (H_TOTAL > 4096 || V_TOTAL > 4096)
         $error("vga_timing_gen: H_TOTAL=%0d V_TOTAL=%0d exceed 4096", H_TOTAL, V_TOTAL);
      if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1)
         $error("vga_timing_gen: porch and sync widths must be >= 1");
   end
`endif
   always_comb begin
      w_hst_nxt = r_hst;
      case (r_hst)
         H_ACT:   if (r_hcnt == 12'(H_ACTIVE - 1)) w_hst_nxt = H_FRONT;
         H_FRONT: if (r_hcnt == 12'(H_ACTIVE + H_FP - 1)) w_hst_nxt = H_SYN;
         H_SYN:   if (r_hcnt == 12'(H_ACTIVE + H_FP + H_SYNC - 1)) w_hst_nxt = H_BACK;
         default: if (w_hwrap) w_hst_nxt = H_ACT;
      endcase
   end
   // Vertical state only moves on the last clock of a line.
   always_comb begin
      w_vst_nxt = r_vst;
      if (w_hwrap)
         case (r_vst)
            V_ACT:   if (r_vcnt == 12'(V_ACTIVE - 1)) w_vst_nxt = V_FRONT;
            V_FRONT: if (r_vcnt == 12'(V_ACTIVE + V_FP - 1)) w_vst_nxt = V_SYN;
            V_SYN:   if (r_vcnt == 12'(V_ACTIVE + V_FP + V_SYNC - 1)) w_vst_nxt = V_BACK;
            default: if (w_vwrap) w_vst_nxt = V_ACT;
         endcase
   end
`ifdef VGA_TIMING_FETCH_EN
   localparam int FETCH_LEAD = 8;
   logic [12:0] w_fh, w_fx;
   logic        w_fwrap, w_fvis, w_fetch;
   // Look FETCH_LEAD pixels ahead, spilling into the next line when past the line end.
   always_comb begin
      w_fh    = {1'b0, r_hcnt} + 13'(FETCH_LEAD);
      w_fwrap = (w_fh >= 13'(H_TOTAL));
      w_fx    = w_fwrap ? w_fh - 13'(H_TOTAL) : w_fh;
      w_fvis  = w_fwrap ? (w_vwrap || (r_vcnt + 12'd1 < 12'(V_ACTIVE))) : (r_vst == V_ACT);
      w_fetch = (w_fx < 13'(H_ACTIVE)) && w_fvis;
   end
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hcnt      <= '0;
         r_vcnt      <= '0;
         r_hst       <= H_ACT;
         r_vst       <= V_ACT;
         hsync       <= ~HS_ON;
         vsync       <= ~VS_ON;
         data_en     <= 1'b0;
         xpos        <= '0;
         ypos        <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame       <= '0;
`ifdef VGA_TIMING_FETCH_EN
         fetch_en    <= 1'b0;
         fetch_x     <= '0;
`endif
      end else begin
         r_hcnt      <= w_hwrap ? 12'd0 : r_hcnt + 12'd1;
         if (w_hwrap) r_vcnt <= w_vwrap ? 12'd0 : r_vcnt + 12'd1;
         r_hst       <= w_hst_nxt;
         r_vst       <= w_vst_nxt;
         hsync       <= (r_hst == H_SYN) ? HS_ON : ~HS_ON;
         vsync       <= (r_vst == V_SYN) ? VS_ON : ~VS_ON;
         data_en     <= w_vis;
         xpos        <= w_vis ? r_hcnt : 12'd0;
         ypos        <= (r_vst == V_ACT) ? r_vcnt : 12'(V_ACTIVE);
         line_start  <= (r_hcnt == 12'd0);
         frame_start <= (r_hcnt == 12'd0) && (r_vcnt == 12'd0);
         if ((r_hcnt == 12'd0) && (r_vcnt == 12'd0)) frame <= frame + 16'd1;
`ifdef VGA_TIMING_FETCH_EN
         fetch_en    <= w_fetch;
         fetch_x     <= w_fetch ? w_fx[11:0] : 12'd0;
`endif
      end
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default-geometry and small inverted-polarity instances checked every clock
// against an arithmetic raster model, plus vector table and line/frame/reset sequences.
module tb_vga_timing_gen;
   localparam int SA = 8, SF = 2, SS = 4, SB = 4;
   localparam int TA = 4, TF = 1, TS = 2, TB = 1;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   logic d0_hs, d0_vs, d0_de, d0_ls, d0_fs, d1_hs, d1_vs, d1_de, d1_ls, d1_fs;
   logic [11:0] d0_x, d0_y, d1_x, d1_y;
   logic [15:0] d0_fr, d1_fr;
`ifdef VGA_TIMING_FETCH_EN
   logic d0_fe, d1_fe;
   logic [11:0] d0_fx, d1_fx;
`endif
   vga_timing_gen d0 (
      .clk(clk), .reset(reset), .hsync(d0_hs), .vsync(d0_vs), .data_en(d0_de),
      .xpos(d0_x), .ypos(d0_y), .line_start(d0_ls), .frame_start(d0_fs), .frame(d0_fr)
`ifdef VGA_TIMING_FETCH_EN
      , .fetch_en(d0_fe), .fetch_x(d0_fx)
`endif
   );
   vga_timing_gen #(
      .H_ACTIVE(SA), .H_FP(SF), .H_SYNC(SS), .H_BP(SB),
      .V_ACTIVE(TA), .V_FP(TF), .V_SYNC(TS), .V_BP(TB), .HS_POL(0), .VS_POL(0)
   ) d1 (
      .clk(clk), .reset(reset), .hsync(d1_hs), .vsync(d1_vs), .data_en(d1_de),
      .xpos(d1_x), .ypos(d1_y), .line_start(d1_ls), .frame_start(d1_fs), .frame(d1_fr)
`ifdef VGA_TIMING_FETCH_EN
      , .fetch_en(d1_fe), .fetch_x(d1_fx)
`endif
   );
   typedef struct {
      logic hs, vs, de, ls, fs;
      logic [11:0] x, y;
      logic [15:0] fr;
      logic fe;
      logic [11:0] fx;
   } exp_t;
   typedef struct {
      int t;
      logic de, hs, ls, fs;
      logic [11:0] x, y;
   } vec_t;
   int n_vec = 0, n_bad = 0;
   longint t_pos = 0, last_t = -1;
   function automatic exp_t model(input int ha, hf, hsw, hb, va, vf, vsw, vb,
                                  input bit hp, vp, rs, input longint t);
      exp_t e;
      longint ht, vt, h, v, f, fh, fv;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vb;
      e = '{default: '0};
      e.hs = ~hp;
      e.vs = ~vp;
      if (!rs) begin
         h = t % ht;
         v = (t / ht) % vt;
         e.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
         e.vs = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
         e.de = (h < ha) && (v < va);
         e.x  = e.de ? 12'(h) : 12'd0;
         e.y  = (v < va) ? 12'(v) : 12'(va);
         e.ls = (h == 0);
         e.fs = (h == 0) && (v == 0);
         e.fr = 16'((t / (ht * vt) + 1) % 65536);
         f  = t + 8;
         fh = f % ht;
         fv = (f / ht) % vt;
         e.fe = (fh < ha) && (fv < va);
         e.fx = e.fe ? 12'(fh) : 12'd0;
      end
      return e;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at t=%0d: got %0d expected %0d", nm, last_t, act, exp);
      end
   endtask
   task automatic cmp(input string tag, input exp_t e, input logic hs, vs, de, ls, fs,
                      input logic [11:0] x, y, input logic [15:0] fr);
      chk({tag, ".hsync"}, 32'(hs), 32'(e.hs));
      chk({tag, ".vsync"}, 32'(vs), 32'(e.vs));
      chk({tag, ".data_en"}, 32'(de), 32'(e.de));
      chk({tag, ".line_start"}, 32'(ls), 32'(e.ls));
      chk({tag, ".frame_start"}, 32'(fs), 32'(e.fs));
      chk({tag, ".xpos"}, 32'(x), 32'(e.x));
      chk({tag, ".ypos"}, 32'(y), 32'(e.y));
      chk({tag, ".frame"}, 32'(fr), 32'(e.fr));
   endtask
   task automatic step(input bit r);
      exp_t e0, e1;
      @(negedge clk);
      reset = r;
      @(posedge clk);
      #1;
      e0 = model(640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1, r, t_pos);
      e1 = model(SA, SF, SS, SB, TA, TF, TS, TB, 1'b0, 1'b0, r, t_pos);
      last_t = r ? -1 : t_pos;
      t_pos  = r ? 0 : t_pos + 1;
      cmp("d0", e0, d0_hs, d0_vs, d0_de, d0_ls, d0_fs, d0_x, d0_y, d0_fr);
      cmp("d1", e1, d1_hs, d1_vs, d1_de, d1_ls, d1_fs, d1_x, d1_y, d1_fr);
`ifdef VGA_TIMING_FETCH_EN
      chk("d0.fetch_en", 32'(d0_fe), 32'(e0.fe));
      chk("d0.fetch_x", 32'(d0_fx), 32'(e0.fx));
      chk("d1.fetch_en", 32'(d1_fe), 32'(e1.fe));
      chk("d1.fetch_x", 32'(d1_fx), 32'(e1.fx));
`endif
   endtask
   initial begin
      vec_t vecs[12];
      int n_de, n_hs, hs_first, ls_gap, n_ls, n_vs, vs_first;
      logic [15:0] f0;
      vecs[0]  = '{0,    1'b1, 1'b0, 1'b1, 1'b1, 12'd0,   12'd0};
      vecs[1]  = '{1,    1'b1, 1'b0, 1'b0, 1'b0, 12'd1,   12'd0};
      vecs[2]  = '{639,  1'b1, 1'b0, 1'b0, 1'b0, 12'd639, 12'd0};
      vecs[3]  = '{640,  1'b0, 1'b0, 1'b0, 1'b0, 12'd0,   12'd0};
      vecs[4]  = '{655,  1'b0, 1'b0, 1'b0, 1'b0, 12'd0,   12'd0};
      vecs[5]  = '{656,  1'b0, 1'b1, 1'b0, 1'b0, 12'd0,   12'd0};
      vecs[6]  = '{751,  1'b0, 1'b1, 1'b0, 1'b0, 12'd0,   12'd0};
      vecs[7]  = '{752,  1'b0, 1'b0, 1'b0, 1'b0, 12'd0,   12'd0};
      vecs[8]  = '{799,  1'b0, 1'b0, 1'b0, 1'b0, 12'd0,   12'd0};
      vecs[9]  = '{800,  1'b1, 1'b0, 1'b1, 1'b0, 12'd0,   12'd1};
      vecs[10] = '{1439, 1'b1, 1'b0, 1'b0, 1'b0, 12'd639, 12'd1};
      vecs[11] = '{1440, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,   12'd1};
      for (int i = 0; i < 5; i++) step(1'b1);
      chk("rst.d1_hsync", 32'(d1_hs), 32'd1);
      chk("rst.d1_vsync", 32'(d1_vs), 32'd1);
      for (int i = 0; i < 12; i++) begin
         while (last_t < vecs[i].t) step(1'b0);
         chk("vec.data_en", 32'(d0_de), 32'(vecs[i].de));
         chk("vec.hsync", 32'(d0_hs), 32'(vecs[i].hs));
         chk("vec.line_start", 32'(d0_ls), 32'(vecs[i].ls));
         chk("vec.frame_start", 32'(d0_fs), 32'(vecs[i].fs));
         chk("vec.xpos", 32'(d0_x), 32'(vecs[i].x));
         chk("vec.ypos", 32'(d0_y), 32'(vecs[i].y));
         chk("vec.frame", 32'(d0_fr), 32'd1);
      end
      while (last_t < 1599) step(1'b0);
      n_de = 0; n_hs = 0; hs_first = -1; ls_gap = -1;
      for (int i = 0; i <= 800; i++) begin
         step(1'b0);
         if (i < 800 && d0_de) n_de++;
         if (i < 800 && d0_hs) n_hs++;
         if (d0_hs && hs_first < 0) hs_first = i;
         if (d0_ls && i > 0 && ls_gap < 0) ls_gap = i;
      end
      chk("line.de_count", 32'(n_de), 32'd640);
      chk("line.hs_count", 32'(n_hs), 32'd96);
      chk("line.hs_offset", 32'(hs_first), 32'd656);
      chk("line.ls_period", 32'(ls_gap), 32'd800);
      for (int i = 0; i < 200 && !d1_fs; i++) step(1'b0);
      chk("small.find_frame_start", 32'(d1_fs), 32'd1);
      f0 = d1_fr;
      n_ls = 0; n_de = 0; n_vs = 0; vs_first = -1;
      for (int i = 0; i < 144; i++) begin
         if (d1_ls) n_ls++;
         if (d1_de) n_de++;
         if (!d1_vs) n_vs++;
         if (!d1_vs && vs_first < 0) vs_first = i;
         step(1'b0);
      end
      chk("small.ls_count", 32'(n_ls), 32'd8);
      chk("small.de_count", 32'(n_de), 32'd32);
      chk("small.vs_count", 32'(n_vs), 32'd36);
      chk("small.vs_offset", 32'(vs_first), 32'd90);
      chk("small.next_fs", 32'(d1_fs), 32'd1);
      chk("small.frame_inc", 32'(d1_fr), 32'(f0 + 16'd1));
      for (int i = 0; i < 800 && (t_pos % 800) != 300; i++) step(1'b0);
      step(1'b1);
      chk("midrst.data_en", 32'(d0_de), 32'd0);
      chk("midrst.xpos", 32'(d0_x), 32'd0);
      chk("midrst.frame", 32'(d0_fr), 32'd0);
      chk("midrst.line_start", 32'(d0_ls), 32'd0);
      step(1'b0);
      chk("restart.frame_start", 32'(d0_fs), 32'd1);
      chk("restart.xpos", 32'(d0_x), 32'd0);
      chk("restart.ypos", 32'(d0_y), 32'd0);
      chk("restart.frame", 32'(d0_fr), 32'd1);
      for (int k = 0; k < 30; k++) begin
         int run, hold;
         run  = $urandom_range(10, 500);
         hold = $urandom_range(1, 3);
         for (int i = 0; i < run; i++) step(1'b0);
         for (int i = 0; i < hold; i++) step(1'b1);
      end
      for (int i = 0; i < 1000; i++) step(1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
